// File: rtl/spi_master_slave_top.sv
// SPI mode-1 link for bring-up: SCLK generator, master (TX/RX FSMs) and slave
// joined by internal SCLK/CS/MOSI/MISO wires inside one module.
module spi_master_slave_top #(
  parameter int MASTER_FREQ = 100_000_000,
  parameter int SLAVE_FREQ  = 1_800_000,
  parameter int SPI_MODE    = 1,
  parameter int SPI_TRF_BIT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req,
  input  logic [7:0]             wait_duration,
  input  logic [SPI_TRF_BIT-1:0] din_master,
  input  logic [SPI_TRF_BIT-1:0] din_slave,
  output logic [SPI_TRF_BIT-1:0] dout_master,
  output logic [SPI_TRF_BIT-1:0] dout_slave,
  output logic                   done_tx,
  output logic                   done_rx
);

  localparam int N    = SPI_TRF_BIT;
  localparam int HALF = MASTER_FREQ / (2 * SLAVE_FREQ);
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int BW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(N - 1);
  localparam logic          CPOL      = (SPI_MODE >= 2);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_LOAD  = 2'd1,
    TX_SHIFT = 2'd2,
    TX_WAIT  = 2'd3
  } tx_state_t;

  typedef enum logic {
    RX_IDLE   = 1'b0,
    RX_ACTIVE = 1'b1
  } rx_state_t;

  // SCLK generator
  logic          sclk_r;
  logic          sclk_posedge_r;
  logic          sclk_negedge_r;
  logic [CW-1:0] sclk_cnt_r;
  logic          sclk_en_s;

  // master
  tx_state_t     state_tx_r;
  rx_state_t     state_rx_r;
  logic [1:0]    req_r;
  logic [7:0]    wait_r;
  logic [7:0]    wait_cnt_r;
  logic [BW-1:0] tx_bit_cnt_r;
  logic [BW-1:0] rx_bit_cnt_r;
  logic [N-1:0]  tx_sh_r;
  logic          tx_first_r;
  logic          cs_r;

  // slave
  logic          cs_d_r;
  logic          slv_rx_r;
  logic          slv_tx_r;
  logic [N-1:0]  slv_sh_r;
  logic          slv_first_r;

  logic          mosi_s;
  logic          miso_s;

  assign sclk_en_s = (state_tx_r == TX_SHIFT);
  assign mosi_s    = req_r[0] & tx_sh_r[N-1];
  assign miso_s    = slv_tx_r & slv_sh_r[N-1];

  // SCLK half-period counter; strobes mark the cycle right after each SCLK edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_r         <= CPOL;
      sclk_cnt_r     <= {CW{1'b0}};
      sclk_posedge_r <= 1'b0;
      sclk_negedge_r <= 1'b0;
    end else if (!sclk_en_s) begin
      sclk_r         <= CPOL;
      sclk_cnt_r     <= {CW{1'b0}};
      sclk_posedge_r <= 1'b0;
      sclk_negedge_r <= 1'b0;
    end else if (sclk_cnt_r == HALF_LAST) begin
      sclk_r         <= ~sclk_r;
      sclk_cnt_r     <= {CW{1'b0}};
      sclk_posedge_r <= (sclk_r == CPOL);
      sclk_negedge_r <= (sclk_r != CPOL);
    end else begin
      sclk_cnt_r     <= sclk_cnt_r + {{(CW-1){1'b0}}, 1'b1};
      sclk_posedge_r <= 1'b0;
      sclk_negedge_r <= 1'b0;
    end
  end

  // Master TX FSM: owns CS, the SCLK burst, MOSI shifting and the post-burst wait
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_tx_r   <= TX_IDLE;
      req_r        <= 2'b00;
      wait_r       <= 8'd0;
      wait_cnt_r   <= 8'd0;
      tx_bit_cnt_r <= {BW{1'b0}};
      tx_sh_r      <= {N{1'b0}};
      tx_first_r   <= 1'b0;
      cs_r         <= 1'b1;
      done_tx      <= 1'b0;
    end else begin
      done_tx <= 1'b0;
      case (state_tx_r)
        TX_IDLE: begin
          if (req != 2'b00) begin
            req_r        <= req;
            wait_r       <= wait_duration;
            tx_sh_r      <= din_master;
            tx_first_r   <= 1'b1;
            tx_bit_cnt_r <= {BW{1'b0}};
            cs_r         <= 1'b0;
            state_tx_r   <= TX_LOAD;
          end
        end
        TX_LOAD: begin
          state_tx_r <= TX_SHIFT;
        end
        TX_SHIFT: begin
          // the first leading edge presents the MSB already loaded
          if (sclk_posedge_r) begin
            if (tx_first_r) begin
              tx_first_r <= 1'b0;
            end else begin
              tx_sh_r <= {tx_sh_r[N-2:0], 1'b0};
            end
          end
          if (sclk_negedge_r) begin
            if (tx_bit_cnt_r == BIT_LAST) begin
              tx_bit_cnt_r <= {BW{1'b0}};
              wait_cnt_r   <= 8'd0;
              if (wait_r == 8'd0) begin
                done_tx    <= req_r[0];
                cs_r       <= 1'b1;
                state_tx_r <= TX_IDLE;
              end else begin
                state_tx_r <= TX_WAIT;
              end
            end else begin
              tx_bit_cnt_r <= tx_bit_cnt_r + {{(BW-1){1'b0}}, 1'b1};
            end
          end
        end
        TX_WAIT: begin
          if (wait_cnt_r == wait_r - 8'd1) begin
            done_tx    <= req_r[0];
            cs_r       <= 1'b1;
            wait_cnt_r <= 8'd0;
            state_tx_r <= TX_IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        default: begin
          cs_r       <= 1'b1;
          state_tx_r <= TX_IDLE;
        end
      endcase
    end
  end

  // Master RX FSM: armed during LOAD, samples MISO on each trailing SCLK edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_rx_r   <= RX_IDLE;
      rx_bit_cnt_r <= {BW{1'b0}};
      dout_master  <= {N{1'b0}};
      done_rx      <= 1'b0;
    end else begin
      done_rx <= 1'b0;
      case (state_rx_r)
        RX_IDLE: begin
          if ((state_tx_r == TX_LOAD) && req_r[1]) begin
            rx_bit_cnt_r <= {BW{1'b0}};
            state_rx_r   <= RX_ACTIVE;
          end
        end
        RX_ACTIVE: begin
          if (sclk_negedge_r) begin
            dout_master <= {dout_master[N-2:0], miso_s};
            if (rx_bit_cnt_r == BIT_LAST) begin
              rx_bit_cnt_r <= {BW{1'b0}};
              done_rx      <= 1'b1;
              state_rx_r   <= RX_IDLE;
            end else begin
              rx_bit_cnt_r <= rx_bit_cnt_r + {{(BW-1){1'b0}}, 1'b1};
            end
          end
        end
        default: begin
          state_rx_r <= RX_IDLE;
        end
      endcase
    end
  end

  // Slave: direction enables follow CS, TX word captured on the CS falling edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_d_r      <= 1'b1;
      slv_rx_r    <= 1'b0;
      slv_tx_r    <= 1'b0;
      slv_sh_r    <= {N{1'b0}};
      slv_first_r <= 1'b0;
      dout_slave  <= {N{1'b0}};
    end else begin
      cs_d_r   <= cs_r;
      slv_rx_r <= ~cs_r & req_r[0];
      slv_tx_r <= ~cs_r & req_r[1];
      if (cs_d_r && !cs_r) begin
        slv_sh_r    <= din_slave;
        slv_first_r <= 1'b1;
      end else if (sclk_posedge_r) begin
        if (slv_first_r) begin
          slv_first_r <= 1'b0;
        end else begin
          slv_sh_r <= {slv_sh_r[N-2:0], 1'b0};
        end
      end
      if (slv_rx_r && sclk_negedge_r) begin
        dout_slave <= {dout_slave[N-2:0], mosi_s};
      end
    end
  end

endmodule

// File: tb/tb_spi_master_slave_top.sv
// Directed bench for spi_master_slave_top: idle, each transfer direction,
// mid-transfer reset and back-to-back words, checked with immediate assertions.
module tb_spi_master_slave_top;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [7:0] wait_duration;
  logic [7:0] din_master;
  logic [7:0] din_slave;
  logic [7:0] dout_master;
  logic [7:0] dout_slave;
  logic       done_tx;
  logic       done_rx;

  int n_assert = 0;
  int n_fail   = 0;

  int cyc = 0;
  int last_fall_cyc = 0;
  int done_tx_cyc = 0;
  int done_rx_cyc = 0;
  int n_done_tx = 0;
  int n_done_rx = 0;
  int n_sclk_hi = 0;
  int n_cs_lo = 0;

  logic [7:0] exp_m;
  logic [7:0] exp_s;

  always #5 clk = ~clk;

  spi_master_slave_top dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .wait_duration (wait_duration),
    .din_master    (din_master),
    .din_slave     (din_slave),
    .dout_master   (dout_master),
    .dout_slave    (dout_slave),
    .done_tx       (done_tx),
    .done_rx       (done_rx)
  );

  // event monitor: done pulses, last SCLK fall, SCLK-high and CS-low cycles
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dut.sclk_negedge_r) last_fall_cyc <= cyc;
    if (done_tx) begin
      n_done_tx   <= n_done_tx + 1;
      done_tx_cyc <= cyc;
    end
    if (done_rx) begin
      n_done_rx   <= n_done_rx + 1;
      done_rx_cyc <= cyc;
    end
    if (dut.sclk_r) n_sclk_hi <= n_sclk_hi + 1;
    if (!dut.cs_r) n_cs_lo <= n_cs_lo + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // one transfer; bit-by-bit expectation comes from the bench's own shift model
  task automatic xfer(input logic [1:0] r, input logic [7:0] dm, input logic [7:0] ds,
                      input logic [7:0] w, input bit hold_req, input logic [7:0] nxt);
    int tx0;
    int rx0;
    bit seen;
    tx0 = n_done_tx;
    rx0 = n_done_rx;
    req = r;
    din_master = dm;
    din_slave = ds;
    wait_duration = w;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      seen = !dut.cs_r;
    end
    chk("cs_fall", 32'(seen), 32'd1);
    if (!hold_req) req = 2'b00;
    din_master = nxt;
    for (int i = 0; i < 8; i++) begin
      seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
        @(posedge clk); #1;
        seen = dut.sclk_negedge_r;
      end
      chk("sclk_fall", 32'(seen), 32'd1);
      @(posedge clk); #1;
      if (r[0]) exp_s = {exp_s[6:0], dm[7-i]};
      if (r[1]) exp_m = {exp_m[6:0], ds[7-i]};
      chk("dout_slave_bit", 32'(dout_slave), 32'(exp_s));
      chk("dout_master_bit", 32'(dout_master), 32'(exp_m));
    end
    repeat (int'(w) + 3) @(posedge clk);
    #1;
    chk("done_tx_count", 32'(n_done_tx - tx0), 32'(r[0]));
    chk("done_rx_count", 32'(n_done_rx - rx0), 32'(r[1]));
    if (r[0]) chk("done_tx_gap", 32'(done_tx_cyc - last_fall_cyc), 32'(int'(w) + 1));
    if (r[1]) chk("done_rx_gap", 32'(done_rx_cyc - last_fall_cyc), 32'd1);
    if (!hold_req) chk("cs_idle", 32'(dut.cs_r), 32'd1);
  endtask

  initial begin
    int tx0;
    int rx0;
    int hi0;
    int lo0;
    logic [7:0] w1;
    logic [7:0] w2;

    rst = 1'b0;
    req = 2'b00;
    wait_duration = 8'd0;
    din_master = 8'h00;
    din_slave = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_dout_master", 32'(dout_master), 32'd0);
    chk("rst_dout_slave", 32'(dout_slave), 32'd0);
    chk("rst_done", 32'({done_tx, done_rx}), 32'd0);
    chk("rst_sclk_cs", 32'({dut.sclk_r, dut.cs_r}), 32'd1);
    rst = 1'b1;

    // idle for 1000 clk
    tx0 = n_done_tx; rx0 = n_done_rx; hi0 = n_sclk_hi; lo0 = n_cs_lo;
    repeat (1000) @(posedge clk);
    #1;
    chk("idle_sclk_high", 32'(n_sclk_hi - hi0), 32'd0);
    chk("idle_cs_low", 32'(n_cs_lo - lo0), 32'd0);
    chk("idle_done_tx", 32'(n_done_tx - tx0), 32'd0);
    chk("idle_done_rx", 32'(n_done_rx - rx0), 32'd0);

    exp_m = 8'h00;
    exp_s = 8'h00;
    xfer(2'b01, 8'hA5, 8'hFF, 8'd10, 1'b0, 8'hA5);
    chk("mosi_dout_slave", 32'(dout_slave), 32'h0000_00A5);
    chk("mosi_dout_master", 32'(dout_master), 32'h0000_0000);

    xfer(2'b10, 8'h99, 8'h3C, 8'd3, 1'b0, 8'h99);
    chk("miso_dout_master", 32'(dout_master), 32'h0000_003C);
    chk("miso_dout_slave_hold", 32'(dout_slave), 32'h0000_00A5);

    xfer(2'b11, 8'h5A, 8'hC3, 8'd5, 1'b0, 8'h5A);
    chk("fdx_dout_slave", 32'(dout_slave), 32'h0000_005A);
    chk("fdx_dout_master", 32'(dout_master), 32'h0000_00C3);
    chk("fdx_rx_before_tx", 32'(done_rx_cyc < done_tx_cyc), 32'd1);

    // reset 300 ns into SHIFT, held for 300 ns
    req = 2'b01;
    din_master = 8'd120;
    wait_duration = 8'd10;
    for (int k = 0; k < 20 && dut.cs_r; k++) begin
      @(posedge clk); #1;
    end
    chk("rst_xfer_cs_fall", 32'(dut.cs_r), 32'd0);
    @(posedge clk); #1;
    #300;
    tx0 = n_done_tx; rx0 = n_done_rx;
    rst = 1'b0;
    req = 2'b00;
    for (int k = 0; k < 30; k++) begin
      #10;
      chk("rst_mid_sclk_done", 32'({dut.sclk_r, done_tx, done_rx}), 32'd0);
    end
    chk("rst_mid_dout_master", 32'(dout_master), 32'd0);
    chk("rst_mid_dout_slave", 32'(dout_slave), 32'd0);
    chk("rst_mid_cs", 32'(dut.cs_r), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_no_done", 32'((n_done_tx - tx0) + (n_done_rx - rx0)), 32'd0);
    exp_m = 8'h00;
    exp_s = 8'h00;
    xfer(2'b01, 8'd120, 8'h00, 8'd0, 1'b0, 8'd120);
    chk("restart_dout_slave", 32'(dout_slave), 32'd120);

    // back-to-back with req held; din_master changed mid-transfer to the next word
    w1 = 8'($urandom_range(0, 255));
    w2 = 8'($urandom_range(0, 255));
    xfer(2'b01, w1, 8'h00, 8'd4, 1'b1, w2);
    chk("b2b_word1", 32'(dout_slave), 32'(w1));
    chk("b2b_restart_cs", 32'(dut.cs_r), 32'd0);
    xfer(2'b01, w2, 8'h00, 8'd4, 1'b0, w2);
    chk("b2b_word2", 32'(dout_slave), 32'(w2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
